// File: rtl/memory_stage_if.sv
// Bundle types and the handshake/data-bus port group of the memory-access stage.
// The stage itself binds to the master modport; the environment binds to slave.
package memory_stage_pkg;

  localparam logic [4:0] EXC_LOAD_MISALIGNED  = 5'd4;
  localparam logic [4:0] EXC_STORE_MISALIGNED = 5'd6;

  // memSize: 0 = byte, 1 = half, 2 = word, 3 = dword
  typedef struct packed {
    logic       memRead;
    logic       memWrite;
    logic       memUnsigned;
    logic [1:0] memSize;
    logic       regWrite;
  } ctl_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] code;
  } excep_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] raw_instr;
    logic [4:0]  dst;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    ctl_t        ctl;
    logic [63:0] writedata;
    logic [63:0] csrdata;
    logic [63:0] memaddr;
    logic [11:0] csraddr;
    excep_t      excep;
    logic [1:0]  priviledgeMode;
  } execute_data_t;

  typedef execute_data_t memory_data_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

endpackage

interface memory_stage_if;
  import memory_stage_pkg::*;

  execute_data_t dataE;
  logic          in_valid;
  logic          in_ready;
  dbus_req_t     dreq;
  dbus_resp_t    dresp;
  memory_data_t  dataM;
  logic          out_valid;
  logic          out_ready;

  modport master (
    input  dataE, in_valid, dresp, out_ready,
    output in_ready, dreq, dataM, out_valid
  );

  modport slave (
    output dataE, in_valid, dresp, out_ready,
    input  in_ready, dreq, dataM, out_valid
  );
endinterface

// File: rtl/memory_stage.sv
// Memory-access pipeline stage: one bus transaction per load/store, load lane
// extraction with sign/zero extension, store lane shifting, registered result.
//
// state | meaning
// IDLE  | output register empty or being drained
// WAIT  | data-bus transaction outstanding
// HOLD  | dataM valid, waiting for writeback to accept it
module memory_stage #(
  parameter int XLEN = 64
) (
  input logic            clk,
  input logic            reset,
  memory_stage_if.master bus
);
  import memory_stage_pkg::*;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]      state;
  memory_data_t    bundle;
  dbus_req_t       reqReg;

  logic            inReady;
  logic            accept;
  logic            isLoad;
  logic            isStore;
  logic            isMemOp;
  logic            misaligned;
  logic [2:0]      offset;
  logic [7:0]      sizeMask;
  dbus_req_t       nextReq;

  logic            holdIsLoad;
  logic            signExt;
  logic [63:0]     laneData;
  logic [XLEN-1:0] loadValue;

  always_comb begin : decodeIn
    inReady    = (state == IDLE) || ((state == HOLD) && bus.out_ready);
    accept     = bus.in_valid && inReady;
    isStore    = bus.dataE.ctl.memWrite;
    isLoad     = bus.dataE.ctl.memRead && !bus.dataE.ctl.memWrite;
    // A bundle that already faulted upstream must not touch the bus.
    isMemOp    = (isLoad || isStore) && !bus.dataE.excep.valid;
    offset     = bus.dataE.memaddr[2:0];
    sizeMask   = 8'h01;
    misaligned = 1'b0;
    case (bus.dataE.ctl.memSize)
      2'd0: begin
        sizeMask   = 8'h01;
        misaligned = 1'b0;
      end
      2'd1: begin
        sizeMask   = 8'h03;
        misaligned = offset[0];
      end
      2'd2: begin
        sizeMask   = 8'h0F;
        misaligned = |offset[1:0];
      end
      default: begin
        sizeMask   = 8'hFF;
        misaligned = |offset;
      end
    endcase

    nextReq       = '0;
    nextReq.valid = 1'b1;
    nextReq.addr  = bus.dataE.memaddr;
    nextReq.size  = {1'b0, bus.dataE.ctl.memSize};
    if (isStore) begin
      nextReq.strobe = sizeMask << offset;
      nextReq.data   = bus.dataE.writedata << {offset, 3'b000};
    end
  end

  always_comb begin : loadAlign
    holdIsLoad = bundle.ctl.memRead && !bundle.ctl.memWrite;
    signExt    = !bundle.ctl.memUnsigned;
    laneData   = bus.dresp.data >> {bundle.memaddr[2:0], 3'b000};
    case (bundle.ctl.memSize)
      2'd0:    loadValue = {{(XLEN-8){signExt & laneData[7]}}, laneData[7:0]};
      2'd1:    loadValue = {{(XLEN-16){signExt & laneData[15]}}, laneData[15:0]};
      2'd2:    loadValue = {{(XLEN-32){signExt & laneData[31]}}, laneData[31:0]};
      default: loadValue = laneData[XLEN-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      bundle <= '0;
      reqReg <= '0;
    end else if (accept) begin
      bundle <= bus.dataE;
      if (!isMemOp) begin
        state <= HOLD;
      end else if (misaligned) begin
        state              <= HOLD;
        bundle.excep.valid <= 1'b1;
        bundle.excep.code  <= isStore ? EXC_STORE_MISALIGNED : EXC_LOAD_MISALIGNED;
      end else begin
        state  <= WAIT;
        reqReg <= nextReq;
      end
    end else begin
      case (state)
        WAIT: begin
          // addr_ok is deliberately ignored; only data_ok retires the access.
          if (bus.dresp.data_ok) begin
            state  <= HOLD;
            reqReg <= '0;
            if (holdIsLoad) bundle.writedata <= loadValue;
          end
        end
        HOLD: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.dreq      = reqReg;
  assign bus.dataM     = bundle;
  assign bus.out_valid = (state == HOLD);

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage with a transaction-level reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_memory_stage;
  import memory_stage_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passes = 0;

  memory_stage_if bus();

  memory_stage #(.XLEN(64)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic execute_data_t mk(input logic rd, input logic wr, input logic uns,
                                       input logic [1:0] size, input logic [63:0] addr,
                                       input logic [63:0] wdata, input logic exc);
    execute_data_t e;
    e                 = '0;
    e.pc              = 64'h8000_0000 + addr;
    e.raw_instr       = 32'h00A5_3023 ^ addr[31:0];
    e.dst             = 5'd10;
    e.ra1             = 5'd11;
    e.ra2             = 5'd12;
    e.ctl.memRead     = rd;
    e.ctl.memWrite    = wr;
    e.ctl.memUnsigned = uns;
    e.ctl.memSize     = size;
    e.ctl.regWrite    = rd;
    e.writedata       = wdata;
    e.csrdata         = 64'hC5C5_0000_0000_5C5C;
    e.memaddr         = addr;
    e.csraddr         = 12'h341;
    e.excep.valid     = exc;
    e.excep.code      = exc ? 5'd2 : 5'd0;
    e.priviledgeMode  = 2'b11;
    return e;
  endfunction

  // ---------------- reference model ----------------
  function automatic int nBytes(input logic [1:0] s);
    return 1 << s;
  endfunction

  function automatic logic isMem(input execute_data_t e);
    return (e.ctl.memRead || e.ctl.memWrite) && !e.excep.valid;
  endfunction

  function automatic logic isMisaligned(input execute_data_t e);
    return (e.memaddr % 64'(nBytes(e.ctl.memSize))) != 64'd0;
  endfunction

  function automatic logic [7:0] expStrobe(input execute_data_t e);
    logic [7:0] s;
    int off;
    s   = '0;
    off = int'(e.memaddr[2:0]);
    if (e.ctl.memWrite)
      for (int i = 0; i < nBytes(e.ctl.memSize); i++) s[off + i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] expStoreData(input execute_data_t e);
    logic [63:0] d;
    int off;
    d   = '0;
    off = int'(e.memaddr[2:0]);
    if (e.ctl.memWrite)
      for (int i = 0; i < nBytes(e.ctl.memSize); i++) d[8*(off + i) +: 8] = e.writedata[8*i +: 8];
    return d;
  endfunction

  function automatic logic [63:0] expLoad(input execute_data_t e, input logic [63:0] raw);
    logic [63:0] v;
    int off;
    int n;
    v   = '0;
    off = int'(e.memaddr[2:0]);
    n   = nBytes(e.ctl.memSize);
    for (int i = 0; i < n; i++) v[8*i +: 8] = raw[8*(off + i) +: 8];
    if (!e.ctl.memUnsigned && v[8*n - 1])
      for (int j = 8*n; j < 64; j++) v[j] = 1'b1;
    return v;
  endfunction

  typedef struct { memory_data_t d; int cyc; } outEnt_t;
  typedef struct { execute_data_t e; int cyc; } reqEnt_t;
  outEnt_t outQ[$];
  reqEnt_t reqQ[$];

  initial begin : model
    int            cyc;
    logic          prevReset;
    logic          expValid;
    logic          expReq;
    logic          expReady;
    execute_data_t e;
    memory_data_t  m;
    cyc       = 0;
    prevReset = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        if (prevReset) begin
          chk1("rst out_valid", bus.out_valid, 1'b0);
          chk1("rst in_ready", bus.in_ready, 1'b1);
          chk1("rst dreq.valid", bus.dreq.valid, 1'b0);
          chk64("rst dreq.strobe", 64'(bus.dreq.strobe), 64'd0);
          chk64("rst dataM.writedata", bus.dataM.writedata, 64'd0);
        end
        outQ.delete();
        reqQ.delete();
      end else begin
        expValid = (outQ.size() > 0) && (outQ[0].cyc <= cyc);
        expReq   = (reqQ.size() > 0) && (reqQ[0].cyc <= cyc);
        expReady = (reqQ.size() == 0) && ((outQ.size() == 0) || (expValid && bus.out_ready));
        chk1("out_valid", bus.out_valid, expValid);
        chk1("in_ready", bus.in_ready, expReady);
        chk1("dreq.valid", bus.dreq.valid, expReq);
        if (expValid && bus.out_valid) begin
          checks++;
          if (bus.dataM === outQ[0].d) passes++;
          else $display("FAIL dataM: got %h, expected %h", bus.dataM, outQ[0].d);
          if (bus.out_ready) void'(outQ.pop_front());
        end
        if (expReq && bus.dreq.valid) begin
          e = reqQ[0].e;
          chk64("dreq.addr", bus.dreq.addr, e.memaddr);
          chk64("dreq.size", 64'(bus.dreq.size), 64'(e.ctl.memSize));
          chk64("dreq.strobe", 64'(bus.dreq.strobe), 64'(expStrobe(e)));
          chk64("dreq.data", bus.dreq.data, expStoreData(e));
          if (bus.dresp.data_ok) begin
            m = e;
            if (e.ctl.memRead && !e.ctl.memWrite) m.writedata = expLoad(e, bus.dresp.data);
            outQ.push_back('{d: m, cyc: cyc + 1});
            void'(reqQ.pop_front());
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          e = bus.dataE;
          m = e;
          if (isMem(e) && isMisaligned(e)) begin
            m.excep.valid = 1'b1;
            m.excep.code  = e.ctl.memWrite ? 5'd6 : 5'd4;
            outQ.push_back('{d: m, cyc: cyc + 1});
          end else if (isMem(e)) begin
            reqQ.push_back('{e: e, cyc: cyc + 1});
          end else begin
            outQ.push_back('{d: m, cyc: cyc + 1});
          end
        end
      end
      prevReset = reset;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input execute_data_t e);
    int t;
    bus.dataE    = e;
    bus.in_valid = 1'b1;
    for (t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.in_ready) break;
    end
    if (t == 50) begin
      checks++;
      $display("FAIL send handshake: in_ready stayed 0, expected 1");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic respond(input int delay, input logic [63:0] data);
    int t;
    for (t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.dreq.valid) break;
    end
    if (t == 50) begin
      checks++;
      $display("FAIL respond wait: dreq.valid stayed 0, expected 1");
    end
    repeat (delay) @(posedge clk);
    #1;
    bus.dresp.data_ok = 1'b1;
    bus.dresp.addr_ok = 1'b1;
    bus.dresp.data    = data;
    @(posedge clk);
    #1;
    bus.dresp.data_ok = 1'b0;
    bus.dresp.addr_ok = 1'b0;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic        uns;
    logic [1:0]  size;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        exc;
    logic [63:0] expW;
  } vec_t;

  vec_t vecs[9];

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    execute_data_t e;
    logic needResp;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.dataE     = '0;
    bus.dresp     = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // non-memory pass-through
    send(mk(1'b0, 1'b0, 1'b0, 2'd3, 64'h0, 64'h1234, 1'b0));
    @(negedge clk);
    chk1("nonmem out_valid", bus.out_valid, 1'b1);
    chk64("nonmem writedata", bus.dataM.writedata, 64'h1234);
    @(posedge clk); #1;

    // signed and unsigned byte loads, data_ok three cycles after request
    fork
      send(mk(1'b1, 1'b0, 1'b0, 2'd0, 64'h8000_0003, 64'h0, 1'b0));
      respond(3, 64'h0000_0000_8000_0000);
    join
    @(negedge clk);
    chk1("lb out_valid", bus.out_valid, 1'b1);
    chk64("lb writedata", bus.dataM.writedata, 64'hFFFF_FFFF_FFFF_FF80);
    @(posedge clk); #1;
    fork
      send(mk(1'b1, 1'b0, 1'b1, 2'd0, 64'h8000_0003, 64'h0, 1'b0));
      respond(3, 64'h0000_0000_8000_0000);
    join
    @(negedge clk);
    chk1("lbu out_valid", bus.out_valid, 1'b1);
    chk64("lbu writedata", bus.dataM.writedata, 64'h80);
    @(posedge clk); #1;

    // halfword store held across stall cycles
    fork
      send(mk(1'b0, 1'b1, 1'b0, 2'd1, 64'h1006, 64'hBEEF, 1'b0));
      respond(5, 64'hDEAD_DEAD_DEAD_DEAD);
      begin
        for (int t = 0; t < 50; t++) begin
          @(negedge clk);
          if (bus.dreq.valid) break;
        end
        for (int i = 0; i < 5; i++) begin
          chk64("sh strobe", 64'(bus.dreq.strobe), 64'hC0);
          chk64("sh data", bus.dreq.data, 64'hBEEF_0000_0000_0000);
          @(negedge clk);
        end
      end
    join
    @(negedge clk);
    chk64("sh writedata", bus.dataM.writedata, 64'hBEEF);
    @(posedge clk); #1;

    // misaligned word load and dword store
    send(mk(1'b1, 1'b0, 1'b0, 2'd2, 64'h1002, 64'h5555, 1'b0));
    @(negedge clk);
    chk1("lw-mis out_valid", bus.out_valid, 1'b1);
    chk1("lw-mis excep.valid", bus.dataM.excep.valid, 1'b1);
    chk64("lw-mis excep.code", 64'(bus.dataM.excep.code), 64'd4);
    chk1("lw-mis dreq.valid", bus.dreq.valid, 1'b0);
    @(posedge clk); #1;
    send(mk(1'b0, 1'b1, 1'b0, 2'd3, 64'h1004, 64'h6666, 1'b0));
    @(negedge clk);
    chk64("sd-mis excep.code", 64'(bus.dataM.excep.code), 64'd6);
    @(posedge clk); #1;

    // HOLD back-pressure, then zero-bubble hand-over
    bus.out_ready = 1'b0;
    send(mk(1'b0, 1'b0, 1'b0, 2'd3, 64'h0, 64'hA1, 1'b0));
    bus.dataE    = mk(1'b0, 1'b0, 1'b0, 2'd3, 64'h8, 64'hB2, 1'b0);
    bus.in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk1("hold in_ready", bus.in_ready, 1'b0);
      chk64("hold writedata", bus.dataM.writedata, 64'hA1);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk1("release in_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk1("b2b out_valid", bus.out_valid, 1'b1);
    chk64("b2b writedata", bus.dataM.writedata, 64'hB2);
    @(posedge clk); #1;

    // reset while a transaction is outstanding; late data_ok is dropped
    send(mk(1'b1, 1'b0, 1'b0, 2'd3, 64'h2000, 64'h0, 1'b0));
    @(negedge clk);
    chk1("wait dreq.valid", bus.dreq.valid, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    bus.dresp.data_ok = 1'b1;
    bus.dresp.data    = 64'h1111_2222_3333_4444;
    @(negedge clk);
    chk1("rstwait out_valid", bus.out_valid, 1'b0);
    chk1("rstwait dreq.valid", bus.dreq.valid, 1'b0);
    @(posedge clk); #1;
    bus.dresp.data_ok = 1'b0;
    @(negedge clk);
    chk1("rstwait out_valid late", bus.out_valid, 1'b0);
    chk1("rstwait dreq.valid late", bus.dreq.valid, 1'b0);
    @(posedge clk); #1;

    // directed vector table
    vecs[0] = '{1'b1, 1'b0, 1'b0, 2'd3, 64'h3000, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h0123_4567_89AB_CDEF};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 2'd2, 64'h3004, 64'h0, 64'h8765_4321_0000_0000, 1'b0, 64'hFFFF_FFFF_8765_4321};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 2'd1, 64'h300A, 64'h0, 64'h0000_0000_F00D_0000, 1'b0, 64'hF00D};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 2'd1, 64'h3006, 64'h0, 64'h7FFF_0000_0000_0000, 1'b0, 64'h7FFF};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 2'd0, 64'h3007, 64'hAB, 64'h0, 1'b0, 64'hAB};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 2'd2, 64'h3004, 64'h1122_3344_5566_7788, 64'h0, 1'b0, 64'h1122_3344_5566_7788};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 2'd2, 64'h3001, 64'h4242, 64'h0, 1'b1, 64'h4242};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 2'd0, 64'h0, 64'h7777, 64'h0, 1'b0, 64'h7777};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 2'd3, 64'h3003, 64'h9999, 64'h0, 1'b0, 64'h9999};
    for (int i = 0; i < 9; i++) begin
      e = mk(vecs[i].rd, vecs[i].wr, vecs[i].uns, vecs[i].size, vecs[i].addr, vecs[i].wdata, vecs[i].exc);
      needResp = (vecs[i].rd || vecs[i].wr) && !vecs[i].exc
                 && ((vecs[i].addr % 64'(1 << vecs[i].size)) == 64'd0);
      if (needResp) begin
        fork
          send(e);
          respond(1 + (i % 3), vecs[i].rdata);
        join
      end else begin
        send(e);
      end
      @(negedge clk);
      chk1($sformatf("vec%0d out_valid", i), bus.out_valid, 1'b1);
      chk64($sformatf("vec%0d writedata", i), bus.dataM.writedata, vecs[i].expW);
      @(posedge clk); #1;
    end

    // stray data_ok while idle must be ignored
    bus.dresp.data_ok = 1'b1;
    bus.dresp.data    = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    chk1("stray out_valid", bus.out_valid, 1'b0);
    @(posedge clk); #1;
    bus.dresp.data_ok = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline memory-access stage between execute and writeback. Accepts one execute-stage bundle at a time and issues at most one data-bus transaction per load or store. Loads get byte-lane extraction and sign or zero extension; stores get strobe and lane shifting. The stage registers the finished `memory_data_t` bundle and holds it for the writeback stage until that stage accepts it.

## Interface
Parameters:
- `XLEN`, default 64: data width; the bus is 64 bits and 8 byte lanes.

Ports:
- `clk` in 1: clock. Reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high reset.
- `dataE` in `execute_data_t`: instruction bundle from execute, carrying `pc`, `raw_instr`, `dst`, `ra1`, `ra2`, `ctl`, `writedata`, `csrdata`, `memaddr`, `csraddr`, `excep`, `priviledgeMode`.
- `in_valid` in 1: `dataE` is valid.
- `in_ready` out 1: the stage can accept `dataE` this cycle.
- `dreq` out `dbus_req_t`, with fields:
  - `valid`: request is live.
  - `addr[63:0]`: access address.
  - `size[2:0]`: 0 = byte, 1 = half, 2 = word, 3 = dword.
  - `strobe[7:0]`: byte-lane write enables.
  - `data[63:0]`: store data.
- `dresp` in `dbus_resp_t`, with fields `addr_ok`, `data_ok`, `data[63:0]`.
- `dataM` out `memory_data_t`: registered result bundle.
- `out_valid` out 1: `dataM` is valid.
- `out_ready` in 1: the downstream stage accepts `dataM`.

## Operation
- Three-state FSM:
  - IDLE: the output register is empty or being drained.
  - WAIT: a bus transaction is outstanding.
  - HOLD: `dataM` is valid and not yet accepted.
- `in_ready` = (state==IDLE) || (state==HOLD && out_ready).
- An input handshake happens when `in_valid && in_ready`. The bundle is captured into an internal register.
  - Non-memory instruction, or one with `excep` already set: go to HOLD next cycle with `dataM` = the bundle. `writedata` and `csrdata` pass through unchanged.
  - Load or store that is aligned (`memaddr` mod size == 0): go to WAIT.
  - Load or store that is misaligned: no bus request. Go to HOLD with `excep` set to load-misaligned or store-misaligned.
- In WAIT, `dreq.valid`=1 with:
  - `addr` = `memaddr`.
  - `size` taken from `ctl`.
  - Store `strobe` = size mask << `memaddr[2:0]`.
  - Store `data` = `writedata` << (8*`memaddr[2:0]`).
  - Loads drive `strobe`=0.
  - All `dreq` fields stay stable until `data_ok`.
- `dresp.data_ok` in WAIT moves the FSM to HOLD the next cycle.
  - Loads: `writedata` = (`dresp.data` >> 8*`memaddr[2:0]`), truncated to size, then sign- or zero-extended per `ctl`.
  - Stores: `writedata` is unchanged.
- `addr_ok` is ignored for sequencing. Only `data_ok` completes the transaction.
- HOLD with `out_ready`: if a new input handshakes in the same cycle, the FSM processes it as from IDLE; otherwise it returns to IDLE.
- All bundle fields other than `writedata` and `excep` copy through unmodified.

## Timing
- Reset values: state=IDLE, `out_valid`=0, `dreq.valid`=0, `dreq.strobe`=0, `dataM`='0, `in_ready`=1.
- Non-memory latency: handshake at cycle N gives `out_valid` at N+1.
- Memory latency: handshake at N gives `dreq.valid` at N+1. With `data_ok` at cycle K ≥ N+1, `out_valid` comes at K+1.
- `dreq.valid` is a registered output, never combinationally derived from `dresp`.
- Back-to-back: in HOLD with `out_ready`=1 and `in_valid`=1, zero bubble cycles.
- `reset` asserted in WAIT abandons the transaction: `dreq.valid` is 0 on the next cycle and `data_ok` arriving later is ignored.
- `data_ok` outside WAIT is ignored.

## Test plan
- Reset, then a non-memory instr with `writedata`=0x1234 handshaked at N → `out_valid`=1 at N+1, `dataM.writedata`=0x1234, `dreq.valid` never high.
- Signed byte load `memaddr`=0x80000003, `dresp.data`=0x00000000_80000000 with `data_ok` 3 cycles after request → `writedata`=0xFFFFFFFF_FFFFFF80. The unsigned variant gives 0x80.
- Halfword store `memaddr`=0x1006, `writedata`=0xBEEF → `dreq.strobe`=0xC0, `dreq.data`=0xBEEF0000_00000000, with `dreq` fields stable across 4 stall cycles.
- Word load at `memaddr`=0x1002 → no `dreq.valid`, `out_valid` next cycle with `excep` = load-misaligned.
- `out_ready`=0 for 5 cycles while in HOLD → `dataM` stable and `in_ready`=0. Then `out_ready`=1 with `in_valid`=1 → new bundle accepted the same cycle.
- `reset` asserted in WAIT, then `data_ok`=1 two cycles later → `out_valid` stays 0 and `dreq.valid`=0.
